// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the QPSK transmit symbol scheduler.
package tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD
    } state_t;

    localparam logic signed [15:0] QPSK_A = 16'h895F;
    localparam logic signed [15:0] QPSK_B = 16'h16A0;

    localparam int OSR_DEFAULT = 6;

endpackage

// File: rtl/sym_fifo.sv
// First-word-fall-through symbol FIFO; flush empties it and overrides a same-edge push.
module sym_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic                        i_flush,
    input  logic signed [DATA_W-1:0]    i_din,
    output logic signed [DATA_W-1:0]    o_dout,
    output logic [$clog2(DEPTH):0]      o_level,
    output logic                        o_full,
    output logic                        o_empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic signed [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]              r_wr;
    logic [AW:0]              r_rd;
    logic                     w_do_push;
    logic                     w_do_pop;

    assign o_level   = r_wr - r_rd;
    assign o_full    = (o_level == LVL_W'(DEPTH));
    assign o_empty   = (o_level == '0);
    assign o_dout    = r_mem[r_rd[AW-1:0]];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
            if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/tx_symbol_scheduler.sv
// Frames buffered QPSK symbols as preamble + payload bursts at one symbol per OSR clocks.
module tx_symbol_scheduler
    import tx_sched_pkg::*;
#(
    parameter int OSR        = OSR_DEFAULT,
    parameter int PRE_LEN    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8,
    parameter int DATA_W     = 16
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic                             i_abort,
    input  logic [LEN_W-1:0]                 i_frame_len,
    input  logic                             i_in_valid,
    input  logic signed [DATA_W-1:0]         i_in_data,
    output logic                             o_in_ready,
    output logic signed [DATA_W-1:0]         o_data_out,
    output logic                             o_read_ready,
    output logic                             o_sym_strobe,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_underrun,
    output logic [$clog2(FIFO_DEPTH):0]      o_fifo_level
);
    localparam int TICK_W  = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int PRE_CW  = $clog2(PRE_LEN) + 1;
    localparam int CNT_W   = (LEN_W > PRE_CW) ? LEN_W : PRE_CW;
    localparam logic signed [DATA_W-1:0] SYM_A = DATA_W'(QPSK_A);
    localparam logic signed [DATA_W-1:0] SYM_B = DATA_W'(QPSK_B);

    state_t                   r_state;
    logic [TICK_W-1:0]        r_tick;
    logic [CNT_W-1:0]         r_cnt;
    logic [LEN_W-1:0]         r_len_q;
    logic                     r_start_pend;
    logic signed [DATA_W-1:0] r_data_out;
    logic                     r_sym_strobe;
    logic                     r_done;
    logic                     r_underrun;

    logic                     w_load;
    logic                     w_pre_done;
    logic                     w_pay_left;
    logic                     w_want;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_full;
    logic                     w_empty;
    logic signed [DATA_W-1:0] w_head;

    assign w_load     = (r_tick == TICK_W'(OSR - 1));
    assign w_pre_done = (r_cnt == CNT_W'(PRE_LEN));
    assign w_pay_left = (r_cnt < CNT_W'(r_len_q));
    // A payload slot is due on this load edge; it pops only if data is present
    assign w_want = w_load && !i_abort &&
                    (((r_state == PREAMBLE) && w_pre_done && (r_len_q != '0)) ||
                     ((r_state == PAYLOAD) && w_pay_left));
    assign w_pop  = w_want && !w_empty;
    assign w_push = i_in_valid && !w_full;

    sym_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_abort),
        .i_din   (i_in_data),
        .o_dout  (w_head),
        .o_level (o_fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_tick       <= '0;
            r_cnt        <= '0;
            r_len_q      <= '0;
            r_start_pend <= 1'b0;
            r_data_out   <= '0;
            r_sym_strobe <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_tick       <= w_load ? '0 : r_tick + TICK_W'(1);
            r_sym_strobe <= 1'b0;
            r_done       <= 1'b0;
            if (i_abort) begin
                r_state      <= IDLE;
                r_data_out   <= '0;
                r_start_pend <= 1'b0;
                r_cnt        <= '0;
            end else begin
                if (i_start && (r_state == IDLE)) r_start_pend <= 1'b1;
                if (w_load) begin
                    case (r_state)
                        IDLE: begin
                            if (r_start_pend || i_start) begin
                                r_len_q      <= i_frame_len;
                                r_underrun   <= 1'b0;
                                r_start_pend <= 1'b0;
                                r_state      <= PREAMBLE;
                                r_data_out   <= SYM_A;
                                r_cnt        <= CNT_W'(1);
                                r_sym_strobe <= 1'b1;
                            end
                        end
                        PREAMBLE: begin
                            r_sym_strobe <= 1'b1;
                            if (!w_pre_done) begin
                                r_data_out <= r_cnt[0] ? SYM_B : SYM_A;
                                r_cnt      <= r_cnt + CNT_W'(1);
                            end else if (r_len_q == '0) begin
                                r_state    <= IDLE;
                                r_data_out <= '0;
                                r_done     <= 1'b1;
                            end else begin
                                r_state    <= PAYLOAD;
                                r_data_out <= w_empty ? '0 : w_head;
                                if (w_empty) r_underrun <= 1'b1;
                                r_cnt      <= CNT_W'(1);
                            end
                        end
                        PAYLOAD: begin
                            r_sym_strobe <= 1'b1;
                            if (w_pay_left) begin
                                r_data_out <= w_empty ? '0 : w_head;
                                if (w_empty) r_underrun <= 1'b1;
                                r_cnt      <= r_cnt + CNT_W'(1);
                            end else begin
                                r_state    <= IDLE;
                                r_data_out <= '0;
                                r_done     <= 1'b1;
                            end
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign o_in_ready   = !w_full;
    assign o_data_out   = r_data_out;
    assign o_read_ready = (r_state != IDLE);
    assign o_busy       = (r_state != IDLE);
    assign o_sym_strobe = r_sym_strobe;
    assign o_done       = r_done;
    assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Directed bench: table of frame vectors plus hand sequences for reset timing and abort.
module tb_tx_symbol_scheduler;
    localparam int OSR        = 6;
    localparam int PRE_LEN    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int LEN_W      = 8;
    localparam int DATA_W     = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [LEN_W-1:0]   frame_len = '0;
    logic               in_valid = 1'b0;
    logic [DATA_W-1:0]  in_data = '0;
    logic               in_ready;
    logic [DATA_W-1:0]  data_out;
    logic               read_ready;
    logic               sym_strobe;
    logic               busy;
    logic               done;
    logic               underrun;
    logic [2:0]         fifo_level;

    tx_symbol_scheduler #(
        .OSR        (OSR),
        .PRE_LEN    (PRE_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEN_W      (LEN_W),
        .DATA_W     (DATA_W)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_abort      (abort),
        .i_frame_len  (frame_len),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (in_ready),
        .o_data_out   (data_out),
        .o_read_ready (read_ready),
        .o_sym_strobe (sym_strobe),
        .o_busy       (busy),
        .o_done       (done),
        .o_underrun   (underrun),
        .o_fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               n_pre;
        logic [7:0][15:0] pre;
        int               level_pre;
        logic [7:0]       flen;
        int               nsym;
        logic [11:0][15:0] exp;
        bit               exp_underrun;
        int               level_after;
    } vec_t;

    localparam logic [15:0] A = 16'h895F;
    localparam logic [15:0] B = 16'h16A0;

    vec_t vecs [5];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic prefill(input int n, input logic [7:0][15:0] vals);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = vals[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int idx;
        int last;
        bit fin;
        idx = 0;
        last = 0;
        fin = 1'b0;
        prefill(v.n_pre, v.pre);
        chk("level_pre", 32'(fifo_level), 32'(v.level_pre));
        chk("in_ready_pre", 32'(in_ready), 32'(v.level_pre < FIFO_DEPTH));
        frame_len = v.flen;
        start     = 1'b1;
        for (int c = 1; c <= (v.nsym + 4) * OSR && !fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (sym_strobe) begin
                if (idx > 0) chk("strobe_spacing", 32'(c - last), 32'(OSR));
                last = c;
                if (done) begin
                    fin = 1'b1;
                    chk("end_data", 32'(data_out), 32'h0);
                    chk("end_read_ready", 32'(read_ready), 32'h0);
                    chk("sym_count", 32'(idx), 32'(v.nsym));
                    chk("underrun", 32'(underrun), 32'(v.exp_underrun));
                end else begin
                    if (idx == 0) chk("underrun_cleared", 32'(underrun), 32'h0);
                    if (idx < 12) chk($sformatf("sym%0d", idx), 32'(data_out), 32'(v.exp[idx]));
                    chk("read_ready", 32'(read_ready), 32'h1);
                    idx++;
                end
            end
        end
        chk("frame_done_seen", 32'(fin), 32'h1);
        repeat (2) @(negedge clk);
        chk("done_one_pulse", 32'(done), 32'h0);
        chk("busy_after", 32'(busy), 32'h0);
        chk("underrun_held", 32'(underrun), 32'(v.exp_underrun));
        chk("level_after", 32'(fifo_level), 32'(v.level_after));
    endtask

    initial begin
        int  c;
        int  nstr;
        bit  seen;

        // Frame vectors
        foreach (vecs[i]) begin
            vecs[i].pre = '0;
            vecs[i].exp = '0;
            vecs[i].exp[0] = A; vecs[i].exp[1] = B; vecs[i].exp[2] = A; vecs[i].exp[3] = B;
        end
        vecs[0].n_pre = 3; vecs[0].pre[0] = 16'h1111; vecs[0].pre[1] = 16'h2222; vecs[0].pre[2] = 16'h3333;
        vecs[0].level_pre = 3; vecs[0].flen = 8'd3; vecs[0].nsym = 7;
        vecs[0].exp[4] = 16'h1111; vecs[0].exp[5] = 16'h2222; vecs[0].exp[6] = 16'h3333;
        vecs[0].exp_underrun = 1'b0; vecs[0].level_after = 0;

        vecs[1].n_pre = 1; vecs[1].pre[0] = 16'h7FFF;
        vecs[1].level_pre = 1; vecs[1].flen = 8'd3; vecs[1].nsym = 7;
        vecs[1].exp[4] = 16'h7FFF; vecs[1].exp[5] = 16'h0000; vecs[1].exp[6] = 16'h0000;
        vecs[1].exp_underrun = 1'b1; vecs[1].level_after = 0;

        vecs[2].n_pre = 2; vecs[2].pre[0] = 16'hAAAA; vecs[2].pre[1] = 16'h5555;
        vecs[2].level_pre = 2; vecs[2].flen = 8'd0; vecs[2].nsym = 4;
        vecs[2].exp_underrun = 1'b0; vecs[2].level_after = 2;

        vecs[3].n_pre = 0; vecs[3].level_pre = 2; vecs[3].flen = 8'd2; vecs[3].nsym = 6;
        vecs[3].exp[4] = 16'hAAAA; vecs[3].exp[5] = 16'h5555;
        vecs[3].exp_underrun = 1'b0; vecs[3].level_after = 0;

        vecs[4].n_pre = 5;
        vecs[4].pre[0] = 16'hC001; vecs[4].pre[1] = 16'hC002; vecs[4].pre[2] = 16'hC003;
        vecs[4].pre[3] = 16'hC004; vecs[4].pre[4] = 16'hC005;
        vecs[4].level_pre = 4; vecs[4].flen = 8'd5; vecs[4].nsym = 9;
        vecs[4].exp[4] = 16'hC001; vecs[4].exp[5] = 16'hC002; vecs[4].exp[6] = 16'hC003;
        vecs[4].exp[7] = 16'hC004; vecs[4].exp[8] = 16'h0000;
        vecs[4].exp_underrun = 1'b1; vecs[4].level_after = 0;

        // Reset values and first-symbol latency
        repeat (3) @(negedge clk);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_read_ready", 32'(read_ready), 32'h0);
        chk("rst_sym_strobe", 32'(sym_strobe), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_underrun", 32'(underrun), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_fifo_level", 32'(fifo_level), 32'h0);
        reset     = 1'b0;
        start     = 1'b1;
        frame_len = '0;
        c = 0;
        seen = 1'b0;
        for (int k = 1; k <= 2 * OSR && !seen; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (sym_strobe) begin
                seen = 1'b1;
                c = k;
                chk("first_sym_data", 32'(data_out), 32'(A));
            end
        end
        chk("first_sym_cycle", 32'(c), 32'(OSR));
        seen = 1'b0;
        for (int k = 0; k < 8 * OSR && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("first_frame_done", 32'(seen), 32'h1);
        nstr = 0;
        for (int k = 0; k < 3 * OSR; k++) begin
            @(negedge clk);
            if (sym_strobe) nstr++;
        end
        chk("idle_no_strobe", 32'(nstr), 32'h0);

        // Table-driven frames
        foreach (vecs[i]) run_frame(vecs[i]);

        // Abort two cycles after the second payload strobe
        prefill(3, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0303, 16'h0202, 16'h0101});
        frame_len = 8'd3;
        start     = 1'b1;
        nstr = 0;
        for (int k = 0; k < 12 * OSR && nstr < PRE_LEN + 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (sym_strobe) nstr++;
        end
        chk("abort_reach_payload", 32'(nstr), 32'(PRE_LEN + 2));
        chk("abort_payload2_data", 32'(data_out), 32'h0202);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_data_out", 32'(data_out), 32'h0);
        chk("abort_read_ready", 32'(read_ready), 32'h0);
        chk("abort_fifo_level", 32'(fifo_level), 32'h0);
        chk("abort_no_done", 32'(done), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        start     = 1'b1;
        frame_len = '0;
        c = 0;
        seen = 1'b0;
        for (int k = 1; k <= 2 * OSR && !seen; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) chk("abort_spurious_done", 32'(done), 32'h0);
            if (sym_strobe) begin
                seen = 1'b1;
                c = k;
                chk("restart_sym", 32'(data_out), 32'(A));
            end
        end
        chk("restart_latency", 32'(c), 32'd3);
        seen = 1'b0;
        for (int k = 0; k < 8 * OSR && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("restart_done", 32'(seen), 32'h1);

        // abort and start together: start must be dropped
        repeat (2) @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        nstr = 0;
        for (int k = 0; k < 2 * OSR; k++) begin
            @(negedge clk);
            if (sym_strobe || busy) nstr++;
        end
        chk("abort_beats_start", 32'(nstr), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_symbol_scheduler.md
Name: tx_symbol_scheduler

Overview:
Sequences the QPSK modulator's symbol stream into tx_lite at the 160 kHz symbol rate derived from the 960 kHz system clock (OSR = 6 clocks per symbol). Buffers upstream symbols in a small FIFO and frames each burst as a fixed preamble followed by a programmable payload length. Drives tx_lite's data_in and read_ready, and reports underrun and frame status to the host.

Parameters:
OSR, 6, clocks per symbol (minimum 2)
PRE_LEN, 8, preamble symbols per frame (minimum 1)
FIFO_DEPTH, 4, symbol FIFO entries (power of 2)
LEN_W, 8, width of frame_len
DATA_W, 16, signed symbol width

Ports:
clk  in  1  system clock, 960 kHz
reset  in  1  synchronous, active-high
start  in  1  one-cycle frame request
abort  in  1  one-cycle immediate frame kill
frame_len  in  LEN_W  payload symbols; captured when the frame is accepted
in_valid  in  1  upstream symbol valid
in_data  in  DATA_W  upstream signed symbol
in_ready  out  1  FIFO not full
data_out  out  DATA_W  symbol to tx_lite data_in
read_ready  out  1  high throughout PREAMBLE and PAYLOAD
sym_strobe  out  1  one-cycle pulse when data_out takes a new symbol
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a frame completes normally
underrun  out  1  sticky; cleared by reset or accepted start
fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values: data_out=0, read_ready=0, sym_strobe=0, busy=0, done=0, underrun=0, tick=0, FIFO empty, state=IDLE, start_pend=0, in_ready=1.
- tick counts 0..OSR-1 and wraps; it runs freely whenever not in reset. The "load edge" is the clock edge where tick==OSR-1.
- All symbol decisions happen only on load edges. data_out and sym_strobe update on the same edge, so sym_strobe is high while tick==0.
- The first possible symbol is visible OSR cycles after reset deasserts.
- start while IDLE sets start_pend. start while busy is ignored.
- States:
  - IDLE: data_out=0, read_ready=0. On a load edge with start_pend (or start high on that edge): capture frame_len into len_q, clear underrun and start_pend, go to PREAMBLE, emit preamble symbol 0.
  - PREAMBLE: emits the PRE_LEN preamble symbols over consecutive load edges. Symbol k is QPSK_A (16'h895F) for even k and QPSK_B (16'h16A0) for odd k. After symbol PRE_LEN-1: if len_q==0, go to IDLE on the next load edge (data_out=0, done pulse); otherwise go to PAYLOAD.
  - PAYLOAD: each load edge pops the FIFO head to data_out. If the FIFO is empty, data_out=0, underrun is set, and the symbol still counts. After len_q symbols, the next load edge goes to IDLE with data_out=0, read_ready=0 and a done pulse.
- done is asserted on the load edge that returns to IDLE, so it coincides with sym_strobe.
- abort (any cycle, any state): on the next edge go to IDLE, data_out=0, read_ready=0, FIFO flushed, start_pend cleared, no done pulse. tick is not reset.
- abort and start on the same cycle: abort wins; start is dropped.
- FIFO:
  - push when in_valid && in_ready; in_ready = level < FIFO_DEPTH.
  - Push and pop on the same edge both take effect, and level is unchanged.
  - A pop on an empty FIFO never bypasses a same-edge push; it counts as an underrun.
  - Pushes are accepted in every state, including IDLE, to allow prefill.
- Arithmetic: the symbol counter is max(LEN_W, $clog2(PRE_LEN)+1) bits. No arithmetic is done on data; symbols pass through unchanged.

Decomposition:
- Package tx_sched_pkg holds:
  - the state enum (IDLE, PREAMBLE, PAYLOAD);
  - QPSK_A/QPSK_B constants as logic signed [15:0];
  - the default OSR = 6.
- Sub-module sym_fifo: synchronous FIFO with parameters DEPTH and DATA_W. Ports: push, pop, flush, din, dout, level, full, empty. dout shows the head (first-word fall-through).

Test Plan:
1. Hold reset for 3 cycles, then release → all outputs at reset values; tick wraps every 6 cycles; sym_strobe stays low while IDLE.
2. Prefill 3 symbols 0x1111, 0x2222, 0x3333; PRE_LEN=4, frame_len=3; pulse start → strobes at 6-cycle spacing give 895F, 16A0, 895F, 16A0, 1111, 2222, 3333. Next load edge: data_out=0000, read_ready falls, done pulses once, underrun=0.
3. Prefill 1 symbol 0x7FFF; frame_len=3 → payload 7FFF, 0000, 0000; underrun=1 and held through IDLE. A new start clears it.
4. Push continuously with the FIFO stalled in IDLE → 4 pushes accepted, in_ready=0, fifo_level=4. The 5th in_data is not stored and appears nowhere in a later frame.
5. Pulse abort two cycles after the second payload strobe → data_out=0 and read_ready=0 on the next edge; fifo_level=0; no done; busy=0. A start 1 cycle later begins a preamble on the next load edge.
6. frame_len=0 with start → exactly PRE_LEN preamble strobes, then done; FIFO contents are untouched.
